onewire_master: RTL and testbench



---
 rtl/onewire_pkg.sv | 25 ++
 rtl/onewire_master_if.sv | 13 +
 rtl/onewire_master.sv | 151 +++++++++++++++
 tb/tb_onewire_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared state encoding and 100 MHz default timing for the 1-Wire byte-read master.
package onewire_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_LOW   = 3'd1,
    RST_WAIT  = 3'd2,
    SLOT_LOW  = 3'd3,
    SLOT_WAIT = 3'd4,
    DONE      = 3'd5
  } ow_state_e;

  // Cycle counts at a 10 ns clock.
  localparam int unsigned DEF_T_RST_LOW     = 48000;
  localparam int unsigned DEF_T_PRES_SAMPLE = 3000;
  localparam int unsigned DEF_T_RST_REC     = 48000;
  localparam int unsigned DEF_T_SLOT_LOW    = 100;
  localparam int unsigned DEF_T_SAMPLE      = 1000;
  localparam int unsigned DEF_T_SLOT_REC    = 6000;

  function automatic logic drives_low(input logic [2:0] st);
    return (st == RST_LOW) || (st == SLOT_LOW);
  endfunction

endpackage

// File: rtl/onewire_master_if.sv
// Status/debug bundle of the 1-Wire master; the open-drain pad stays a plain inout on the top.
interface onewire_master_if;
  logic        en;
  logic [7:0]  mem;
  logic        init;
  logic [31:0] cnt;
  logic        cycl;
  logic        rcvd;
  logic        idata;

  modport master (output en, mem, init, cnt, cycl, rcvd, idata);
  modport slave  (input  en, mem, init, cnt, cycl, rcvd, idata);
endinterface

// File: rtl/onewire_master.sv
// 1-Wire master: bus reset, presence sample, then eight read slots collecting one byte LSB first.
// Define ONEWIRE_SIM_PULLUP_EN to add a simulation pull-up on the pad.
//
// state     | meaning
// RST_LOW   | bus reset pulse, line held low
// RST_WAIT  | line released, presence sampled, reset recovery
// SLOT_LOW  | read slot initiation, line held low
// SLOT_WAIT | line released, data bit sampled, slot recovery
// DONE      | byte complete, flag it
// IDLE      | sequence finished, outputs hold until reset
module onewire_master
  import onewire_pkg::*;
#(
  parameter int unsigned T_RST_LOW     = DEF_T_RST_LOW,
  parameter int unsigned T_PRES_SAMPLE = DEF_T_PRES_SAMPLE,
  parameter int unsigned T_RST_REC     = DEF_T_RST_REC,
  parameter int unsigned T_SLOT_LOW    = DEF_T_SLOT_LOW,
  parameter int unsigned T_SAMPLE      = DEF_T_SAMPLE,
  parameter int unsigned T_SLOT_REC    = DEF_T_SLOT_REC
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire              port,
  onewire_master_if.master ow
);

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_RST_LOW   = RST_LOW;
  localparam logic [2:0] S_RST_WAIT  = RST_WAIT;
  localparam logic [2:0] S_SLOT_LOW  = SLOT_LOW;
  localparam logic [2:0] S_SLOT_WAIT = SLOT_WAIT;
  localparam logic [2:0] S_DONE      = DONE;

  logic [2:0]  state_q, state_d;
  logic        arm_q;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  mem_q, mem_d;
  logic        en_q, en_d;
  logic        init_q, init_d;
  logic        cycl_q, cycl_d;
  logic        rcvd_q, rcvd_d;
  logic        idata_q, idata_d;
  logic        line;

  // Open drain: only ever pull low, never drive a 1.
  assign port = en_q ? 1'bz : 1'b0;
  assign line = port;

`ifdef ONEWIRE_SIM_PULLUP_EN
  pullup (port);
`else
  // A released line relies on the external pad pull-up.
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    bit_d   = bit_q;
    mem_d   = mem_q;
    init_d  = init_q;
    rcvd_d  = rcvd_q;
    idata_d = idata_q;

    // arm_q marks the first cycle after reset: it is the entry edge of RST_LOW.
    if (arm_q) begin
      state_d = S_RST_LOW;
      bit_d   = 3'd0;
    end else begin
      case (state_q)
        S_RST_LOW: begin
          bit_d = 3'd0;
          if (cnt_q == T_RST_LOW - 1) state_d = S_RST_WAIT;
        end
        S_RST_WAIT: begin
          if (cnt_q == T_PRES_SAMPLE) begin
            init_d  = ~line;
            idata_d = line;
          end
          if (cnt_q == T_RST_REC - 1) begin
            if (init_q) begin
              state_d = S_SLOT_LOW;
            end else begin
              state_d = S_IDLE;
              rcvd_d  = 1'b0;
            end
          end
        end
        S_SLOT_LOW: begin
          if (cnt_q == T_SLOT_LOW - 1) state_d = S_SLOT_WAIT;
        end
        S_SLOT_WAIT: begin
          if (cnt_q == T_SAMPLE) begin
            mem_d[bit_q] = line;
            idata_d      = line;
          end
          if (cnt_q == T_SLOT_REC - 1) begin
            bit_d   = bit_q + 3'd1;
            state_d = (bit_q == 3'd7) ? S_DONE : S_SLOT_LOW;
          end
        end
        S_DONE: begin
          rcvd_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (arm_q || (state_d != state_q)) cnt_d = 32'd0;

    // Registered outputs follow the state being entered so each phase lasts exactly its count.
    en_d   = ~drives_low(state_d);
    cycl_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST_LOW;
      arm_q   <= 1'b1;
      cnt_q   <= 32'd0;
      bit_q   <= 3'd0;
      mem_q   <= 8'h00;
      en_q    <= 1'b1;
      init_q  <= 1'b0;
      cycl_q  <= 1'b0;
      rcvd_q  <= 1'b0;
      idata_q <= 1'b1;
    end else begin
      state_q <= state_d;
      arm_q   <= 1'b0;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      mem_q   <= mem_d;
      en_q    <= en_d;
      init_q  <= init_d;
      cycl_q  <= cycl_d;
      rcvd_q  <= rcvd_d;
      idata_q <= idata_d;
    end
  end

  assign ow.en    = en_q;
  assign ow.mem   = mem_q;
  assign ow.init  = init_q;
  assign ow.cnt   = cnt_q;
  assign ow.cycl  = cycl_q;
  assign ow.rcvd  = rcvd_q;
  assign ow.idata = idata_q;

endmodule

// File: tb/tb_onewire_master.sv
// Bench for onewire_master with scaled timing and a behavioural 1-Wire slave on the pad.
module tb_onewire_master;
  import onewire_pkg::*;

  localparam int unsigned RL = 400;
  localparam int unsigned PS = 30;
  localparam int unsigned RR = 400;
  localparam int unsigned SL = 4;
  localparam int unsigned SA = 15;
  localparam int unsigned SR = 60;
  localparam int T_PITCH = SL + SR;
  localparam int T_DONE  = RL + RR + 8 * T_PITCH + 1;
  localparam int T_NOSLV = RL + RR;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sdrv;
  wire  port_w;

  logic [7:0] slave_byte = 8'h00;
  bit         slave_present = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int runs_q[$];
  int falls_q[$];

  assign port_w = sdrv ? 1'b0 : 1'bz;
  pullup (port_w);

  onewire_master_if ow ();

  onewire_master #(
    .T_RST_LOW(RL), .T_PRES_SAMPLE(PS), .T_RST_REC(RR),
    .T_SLOT_LOW(SL), .T_SAMPLE(SA), .T_SLOT_REC(SR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .port(port_w),
    .ow(ow)
  );

  always #5 clk = ~clk;

  // Slave: long low = bus reset -> presence pulse; each short master low = one slot,
  // a 0 bit is answered by holding the line low 40 cycles from the falling edge.
  initial begin
    int low_run;
    int pt;
    int scnt;
    int bidx;
    bit pres_on;
    low_run = 0; pt = -1; scnt = 0; bidx = 8;
    sdrv = 1'b0;
    forever begin
      @(negedge clk);
      if (ow.en === 1'b0) begin
        low_run++;
        if (low_run == 1 && bidx < 8) begin
          if (!slave_byte[bidx]) scnt = 40;
          bidx++;
        end
      end else begin
        if (low_run >= 200) begin
          pt   = 0;
          scnt = 0;
          bidx = slave_present ? 0 : 8;
        end
        low_run = 0;
      end
      pres_on = 1'b0;
      if (pt >= 0) begin
        pres_on = slave_present && (pt >= 5) && (pt < 55);
        pt++;
        if (pt >= 55) pt = -1;
      end
      sdrv = pres_on || (scnt > 0);
      if (scnt > 0) scnt--;
    end
  end

  // Pulses reset for one cycle, then follows the sequence until cycl drops (bounded).
  task automatic do_read(input logic [7:0] b, input bit pres, output int t_idle, output int t_rcvd);
    bit in_low;
    int len;
    slave_byte = b;
    slave_present = pres;
    runs_q.delete();
    falls_q.delete();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    t_idle = -1; t_rcvd = -1; in_low = 1'b0; len = 0;
    for (int n = 0; n < T_DONE + 20 && t_idle < 0; n++) begin
      @(posedge clk); #1;
      if (port_w === 1'b0) begin
        if (!in_low) begin
          in_low = 1'b1;
          falls_q.push_back(n);
          len = 0;
        end
        len++;
      end else if (in_low) begin
        runs_q.push_back(len);
        in_low = 1'b0;
      end
      if (t_rcvd < 0 && ow.rcvd === 1'b1) t_rcvd = n;
      if (ow.cycl === 1'b0) t_idle = n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    slave_present = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ow.en, ow.init, ow.cycl, ow.rcvd, ow.idata} !== 5'b10001) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want %b", {ow.en, ow.init, ow.cycl, ow.rcvd, ow.idata}, 5'b10001);
    end
    n_cmp++;
    if (ow.mem !== 8'h00) begin n_bad++; $display("FAIL reset_mem: got %h want 00", ow.mem); end
    n_cmp++;
    if (ow.cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", ow.cnt); end
    n_cmp++;
    if (port_w !== 1'b1) begin n_bad++; $display("FAIL reset_line: got %b want 1", port_w); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({ow.en, ow.cycl, (ow.cnt == 32'd0)} !== 3'b011) begin
      n_bad++;
      $display("FAIL first_cycle: en=%b cycl=%b cnt=%0d want en=0 cycl=1 cnt=0", ow.en, ow.cycl, ow.cnt);
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (ow.cnt !== 32'd5) begin n_bad++; $display("FAIL cnt_count: got %0d want 5", ow.cnt); end
  endtask

  task automatic test_read_aa();
    int ti, tr;
    do_read(8'hAA, 1'b1, ti, tr);
    n_cmp++;
    if (tr !== T_DONE) begin n_bad++; $display("FAIL aa_rcvd_time: got %0d want %0d", tr, T_DONE); end
    n_cmp++;
    if (ti !== T_DONE) begin n_bad++; $display("FAIL aa_idle_time: got %0d want %0d", ti, T_DONE); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ow.mem, ow.init, ow.rcvd, ow.cycl, ow.en, ow.idata} !== {8'hAA, 5'b11011}) begin
      n_bad++;
      $display("FAIL aa_result: got mem=%h init=%b rcvd=%b cycl=%b en=%b idata=%b want mem=aa 1 1 0 1 1",
               ow.mem, ow.init, ow.rcvd, ow.cycl, ow.en, ow.idata);
    end
  endtask

  task automatic test_no_slave();
    int ti, tr;
    do_read(8'h00, 1'b0, ti, tr);
    n_cmp++;
    if (ti !== T_NOSLV) begin n_bad++; $display("FAIL noslave_idle_time: got %0d want %0d", ti, T_NOSLV); end
    n_cmp++;
    if (tr !== -1) begin n_bad++; $display("FAIL noslave_rcvd: rose at %0d want never", tr); end
    repeat (T_PITCH * 2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ow.mem, ow.init, ow.rcvd, ow.cycl, ow.en, ow.idata} !== {8'h00, 5'b00011}) begin
      n_bad++;
      $display("FAIL noslave_result: got mem=%h init=%b rcvd=%b cycl=%b en=%b idata=%b want 00 0 0 0 1 1",
               ow.mem, ow.init, ow.rcvd, ow.cycl, ow.en, ow.idata);
    end
  endtask

  task automatic test_back_to_back();
    int ti, tr;
    do_read(8'hFF, 1'b1, ti, tr);
    n_cmp++;
    if ({ow.mem, ow.init, ow.rcvd} !== {8'hFF, 2'b11} || tr !== T_DONE) begin
      n_bad++;
      $display("FAIL ff_result: got mem=%h init=%b rcvd=%b t=%0d want ff 1 1 t=%0d", ow.mem, ow.init, ow.rcvd, tr, T_DONE);
    end
    // Line probe: reset pulse, presence, then eight undisturbed slot lows.
    n_cmp++;
    if (runs_q.size() !== 10) begin n_bad++; $display("FAIL probe_runs: got %0d low runs want 10", runs_q.size()); end
    n_cmp++;
    if (runs_q[0] !== int'(RL)) begin n_bad++; $display("FAIL probe_rst_low: got %0d want %0d", runs_q[0], RL); end
    n_cmp++;
    if (falls_q[2] !== T_NOSLV) begin n_bad++; $display("FAIL probe_slot0_start: got %0d want %0d", falls_q[2], T_NOSLV); end
    for (int i = 2; i < 10; i++) begin
      n_cmp++;
      if (runs_q[i] !== int'(SL)) begin n_bad++; $display("FAIL probe_slot_low[%0d]: got %0d want %0d", i - 2, runs_q[i], SL); end
    end
    for (int i = 2; i < 9; i++) begin
      n_cmp++;
      if (falls_q[i + 1] - falls_q[i] !== T_PITCH) begin
        n_bad++;
        $display("FAIL probe_pitch[%0d]: got %0d want %0d", i - 2, falls_q[i + 1] - falls_q[i], T_PITCH);
      end
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (ow.rcvd !== 1'b0) begin n_bad++; $display("FAIL between_rcvd: got %b want 0", ow.rcvd); end
    do_read(8'h00, 1'b1, ti, tr);
    n_cmp++;
    if ({ow.mem, ow.rcvd, ow.idata} !== {8'h00, 2'b10} || tr !== T_DONE) begin
      n_bad++;
      $display("FAIL zero_result: got mem=%h rcvd=%b idata=%b t=%0d want 00 1 0 t=%0d", ow.mem, ow.rcvd, ow.idata, tr, T_DONE);
    end
  endtask

  task automatic test_abort();
    int ti, tr;
    slave_byte = 8'hAA;
    slave_present = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (RL + RR + 3 * T_PITCH + 30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({ow.en, ow.cycl, ow.mem} !== {2'b10, 8'h00} || ow.cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL abort_next: got en=%b cycl=%b mem=%h cnt=%0d want 1 0 00 0", ow.en, ow.cycl, ow.mem, ow.cnt);
    end
    do_read(8'hAA, 1'b1, ti, tr);
    n_cmp++;
    if (runs_q[0] !== int'(RL)) begin n_bad++; $display("FAIL abort_rst_low: got %0d want %0d", runs_q[0], RL); end
    n_cmp++;
    if (ow.mem !== 8'hAA || tr !== T_DONE) begin
      n_bad++;
      $display("FAIL abort_reread: got mem=%h t=%0d want aa t=%0d", ow.mem, tr, T_DONE);
    end
  endtask

  task automatic test_random();
    int ti, tr;
    logic [7:0] b;
    bit pres;
    logic [7:0] exp_mem;
    int exp_idle, exp_rcvd;
    logic exp_idata;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom_range(255, 0));
      pres = ($urandom_range(3, 0) != 0);
      exp_mem   = pres ? b : 8'h00;
      exp_idle  = pres ? T_DONE : T_NOSLV;
      exp_rcvd  = pres ? T_DONE : -1;
      exp_idata = pres ? b[7] : 1'b1;
      do_read(b, pres, ti, tr);
      n_cmp++;
      if ({ow.mem, ow.init, ow.rcvd, ow.idata} !== {exp_mem, pres, pres, exp_idata} || ti !== exp_idle || tr !== exp_rcvd) begin
        n_bad++;
        $display("FAIL random[%0d] byte=%h pres=%0d: got mem=%h init=%b rcvd=%b idata=%b ti=%0d tr=%0d want mem=%h init=%b idata=%b ti=%0d tr=%0d",
                 k, b, pres, ow.mem, ow.init, ow.rcvd, ow.idata, ti, tr, exp_mem, pres, exp_idata, exp_idle, exp_rcvd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_aa();
    test_no_slave();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
